// File: rtl/conv2d_run_sequencer.sv
// -----------------------------------------------------------------------------
// conv2d_run_sequencer
//
// Batch run controller for an HLS conv2D core that uses the ap_ctrl_hs
// block-level handshake. It launches the core a programmed number of times,
// with an optional idle gap between runs. It measures the latency of each run,
// counts completed runs, and raises a sticky interrupt when the batch ends.
//
// Ports
//   ap_clk, ap_rst_n    clock (rising edge) and asynchronous active-low reset
//   cfg_start           batch start pulse; accepted only in IDLE with core idle
//   cfg_num_runs        runs in the batch, latched when a start is accepted
//   cfg_gap             idle cycles between runs, latched when a start is accepted
//   cfg_abort           stop the batch after the run in progress
//   core_ap_start       registered start to the core
//   core_ap_ready/done  core handshake inputs (done is a 1-cycle pulse)
//   core_ap_idle        core idle indication
//   busy                batch in progress (held through the FINISH cycle)
//   seq_done            1-cycle pulse in the FINISH cycle
//   runs_done           runs completed in the current or last batch
//   last_latency        cycles from start rise to done, inclusive, of last run
//   irq / irq_clr       sticky batch-complete interrupt and its clear
// -----------------------------------------------------------------------------
module conv2d_run_sequencer #(
    parameter int CNT_W = 16,
    parameter int CYC_W = 32,
    parameter int GAP_W = 8
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             cfg_start,
    input  logic [CNT_W-1:0] cfg_num_runs,
    input  logic [GAP_W-1:0] cfg_gap,
    input  logic             cfg_abort,
    output logic             core_ap_start,
    input  logic             core_ap_ready,
    input  logic             core_ap_done,
    input  logic             core_ap_idle,
    output logic             busy,
    output logic             seq_done,
    output logic [CNT_W-1:0] runs_done,
    output logic [CYC_W-1:0] last_latency,
    output logic             irq,
    input  logic             irq_clr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_DONE,
        S_GAP,
        S_FINISH
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_num_runs;
    logic [GAP_W-1:0] r_gap;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [CYC_W-1:0] r_lat_cnt;
    logic             r_abort_pending;
    logic             r_start;
    logic             r_busy;
    logic             r_seq_done;
    logic [CNT_W-1:0] r_runs_done;
    logic [CYC_W-1:0] r_last_latency;
    logic             r_irq;

    logic             w_run_done;
    logic [CYC_W-1:0] w_lat_next;
    logic [CNT_W-1:0] w_runs_next;

    // A run completes on done, either in WAIT_DONE or in the same cycle the
    // core accepts the start.
    assign w_run_done  = ((r_state == S_LAUNCH) && core_ap_ready && core_ap_done) ||
                         ((r_state == S_WAIT_DONE) && core_ap_done);
    // The latency counter saturates at all-ones rather than wrapping.
    assign w_lat_next  = (&r_lat_cnt) ? r_lat_cnt : r_lat_cnt + CYC_W'(1);
    assign w_runs_next = r_runs_done + CNT_W'(1);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            // NOTE: every output is a register, so reset clears the whole
            // interface at once. The core shares this reset.
            r_state         <= S_IDLE;
            r_num_runs      <= '0;
            r_gap           <= '0;
            r_gap_cnt       <= '0;
            r_lat_cnt       <= '0;
            r_abort_pending <= 1'b0;
            r_start         <= 1'b0;
            r_busy          <= 1'b0;
            r_seq_done      <= 1'b0;
            r_runs_done     <= '0;
            r_last_latency  <= '0;
            r_irq           <= 1'b0;
        end else begin
            r_seq_done <= 1'b0;

            // The set is evaluated first, so it wins over a coincident clear.
            if (r_state == S_FINISH)
                r_irq <= 1'b1;
            else if (irq_clr)
                r_irq <= 1'b0;

            if ((r_state != S_IDLE) && cfg_abort)
                r_abort_pending <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (cfg_start && core_ap_idle) begin
                        r_num_runs      <= cfg_num_runs;
                        r_gap           <= cfg_gap;
                        r_runs_done     <= '0;
                        r_abort_pending <= 1'b0;
                        r_busy          <= 1'b1;
                        if (cfg_num_runs == '0) begin
                            r_state    <= S_FINISH;
                            r_seq_done <= 1'b1;
                        end else begin
                            r_state   <= S_LAUNCH;
                            r_start   <= 1'b1;
                            r_lat_cnt <= CYC_W'(1);
                        end
                    end
                end
                S_LAUNCH: begin
                    r_lat_cnt <= w_lat_next;
                    // Start is held until ready is seen, even with abort pending.
                    if (core_ap_ready) begin
                        r_start <= 1'b0;
                        r_state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    r_lat_cnt <= w_lat_next;
                end
                S_GAP: begin
                    if (r_abort_pending) begin
                        r_state    <= S_FINISH;
                        r_seq_done <= 1'b1;
                    end else if (r_gap_cnt == '0) begin
                        r_state   <= S_LAUNCH;
                        r_start   <= 1'b1;
                        r_lat_cnt <= CYC_W'(1);
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    end
                end
                S_FINISH: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            // NOTE: this block follows the case statement, so its non-blocking
            // assignments override the ones made there. A completed run
            // therefore decides the next state, start and latency count.
            if (w_run_done) begin
                r_last_latency <= r_lat_cnt;
                r_runs_done    <= w_runs_next;
                if ((w_runs_next == r_num_runs) || r_abort_pending) begin
                    r_state    <= S_FINISH;
                    r_seq_done <= 1'b1;
                end else if (r_gap == '0) begin
                    r_state   <= S_LAUNCH;
                    r_start   <= 1'b1;
                    r_lat_cnt <= CYC_W'(1);
                end else begin
                    // A gap of G cycles is loaded as G-1 because the 0 count
                    // is itself the last gap cycle.
                    r_state   <= S_GAP;
                    r_gap_cnt <= r_gap - GAP_W'(1);
                end
            end
        end
    end

    assign core_ap_start = r_start;
    assign busy          = r_busy;
    assign seq_done      = r_seq_done;
    assign runs_done     = r_runs_done;
    assign last_latency  = r_last_latency;
    assign irq           = r_irq;

endmodule

// File: tb/tb_conv2d_run_sequencer.sv
// -----------------------------------------------------------------------------
// tb_conv2d_run_sequencer
//
// Testbench for conv2d_run_sequencer. A behavioural core answers each start
// with ready and done at programmable offsets from the start cycle. For each
// batch, the expected launch cycles, the finish cycle and the final counters
// come from plain arithmetic on the batch parameters. A monitor records the
// launches and seq_done pulses that the DUT actually produces.
// -----------------------------------------------------------------------------
module tb_conv2d_run_sequencer;

    localparam int CNT_W = 16;
    localparam int CYC_W = 32;
    localparam int GAP_W = 8;

    logic             ap_clk        = 1'b0;
    logic             ap_rst_n      = 1'b1;
    logic             cfg_start     = 1'b0;
    logic [CNT_W-1:0] cfg_num_runs  = '0;
    logic [GAP_W-1:0] cfg_gap       = '0;
    logic             cfg_abort     = 1'b0;
    logic             core_ap_start;
    logic             core_ap_ready = 1'b0;
    logic             core_ap_done  = 1'b0;
    logic             core_ap_idle  = 1'b1;
    logic             busy;
    logic             seq_done;
    logic [CNT_W-1:0] runs_done;
    logic [CYC_W-1:0] last_latency;
    logic             irq;
    logic             irq_clr       = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int exp_last_lat = 0;

    conv2d_run_sequencer #(.CNT_W(CNT_W), .CYC_W(CYC_W), .GAP_W(GAP_W)) dut (
        .ap_clk        (ap_clk),
        .ap_rst_n      (ap_rst_n),
        .cfg_start     (cfg_start),
        .cfg_num_runs  (cfg_num_runs),
        .cfg_gap       (cfg_gap),
        .cfg_abort     (cfg_abort),
        .core_ap_start (core_ap_start),
        .core_ap_ready (core_ap_ready),
        .core_ap_done  (core_ap_done),
        .core_ap_idle  (core_ap_idle),
        .busy          (busy),
        .seq_done      (seq_done),
        .runs_done     (runs_done),
        .last_latency  (last_latency),
        .irq           (irq),
        .irq_clr       (irq_clr)
    );

    always #5 ap_clk = ~ap_clk;
    always @(posedge ap_clk) cyc <= cyc + 1;

    // Behavioural core: ready and done appear rdy_off and done_off cycles
    // after the cycle in which a run's start is first seen.
    int rdy_off = 0, done_off = 0, core_k = 0;
    bit force_busy = 1'b0, core_active = 1'b0;
    always begin
        @(posedge ap_clk); #2;
        if (!ap_rst_n) begin
            core_active = 1'b0; core_ap_ready = 1'b0; core_ap_done = 1'b0; core_ap_idle = 1'b1;
        end else begin
            if (core_active) core_k++;
            else if (core_ap_start === 1'b1) begin core_active = 1'b1; core_k = 0; end
            core_ap_ready = core_active && (core_k == rdy_off);
            core_ap_done  = core_active && (core_k == done_off);
            core_ap_idle  = !core_active && !force_busy;
            if (core_ap_done) core_active = 1'b0;
        end
    end

    // Monitor: a launch is a start-high cycle that is not the continuation of
    // a start still waiting for ready.
    int start_q[$];
    int sd_q[$];
    int hi_cnt = 0;
    bit prev_start = 1'b0, prev_ready = 1'b0;
    always begin
        @(posedge ap_clk); #3;
        if (core_ap_start === 1'b1) begin
            if (!prev_start || prev_ready) start_q.push_back(cyc);
            hi_cnt++;
        end
        if (seq_done === 1'b1) sd_q.push_back(cyc);
        prev_start = (core_ap_start === 1'b1);
        prev_ready = (core_ap_ready === 1'b1);
    end

    // amode: 0 no abort, 1 abort in WAIT_DONE of run ak, 2 abort in the gap after run ak
    task automatic run_batch(input string name, input int n, input int g, input int r, input int d,
                             input int amode, input int ak, input bit clr_fin, input bit spur);
        int t0, f_cyc, abort_cyc, exp_runs;
        int exp_s[$];
        bit seen;
        rdy_off = r; done_off = d;
        @(posedge ap_clk); #1;
        start_q.delete(); sd_q.delete(); hi_cnt = 0;
        t0 = cyc;
        exp_runs = (n == 0) ? 0 : ((amode != 0) ? ak : n);
        for (int i = 0; i < exp_runs; i++)
            exp_s.push_back((i == 0) ? t0 + 1 : exp_s[i-1] + d + 1 + g);
        if (n == 0)          f_cyc = t0 + 1;
        else if (amode == 2) f_cyc = exp_s[ak-1] + d + 3;
        else                 f_cyc = exp_s[exp_runs-1] + d + 1;
        abort_cyc = (amode == 1) ? exp_s[ak-1] + r + 1 : (amode == 2) ? exp_s[ak-1] + d + 1 : -1;
        if (exp_runs > 0) exp_last_lat = d + 1;

        cfg_num_runs = CNT_W'(n); cfg_gap = GAP_W'(g); cfg_start = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < f_cyc - t0 + 20 && !seen; i++) begin
            @(posedge ap_clk); #1;
            cfg_start    = spur && (cyc == t0 + 2);
            cfg_num_runs = CNT_W'($urandom);
            cfg_gap      = GAP_W'($urandom);
            cfg_abort    = (cyc == abort_cyc);
            irq_clr      = clr_fin && (cyc == f_cyc);
            if (seq_done === 1'b1) begin
                seen = 1'b1;
                n_vec++; if (cyc !== f_cyc) begin n_err++; $display("FAIL %s finish_cycle: got %0d expected %0d", name, cyc - t0, f_cyc - t0); end
                n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL %s busy_in_finish: got %b expected 1", name, busy); end
                n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL %s irq_before_set: got %b expected 0", name, irq); end
            end
        end
        cfg_start = 1'b0;
        if (!seen) begin n_vec++; n_err++; $display("FAIL %s timeout: seq_done not seen by cycle %0d", name, f_cyc - t0 + 20); end

        @(posedge ap_clk); #1;
        cfg_abort = 1'b0; irq_clr = 1'b1;
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL %s irq_set: got %b expected 1", name, irq); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL %s busy_after: got %b expected 0", name, busy); end
        n_vec++; if (runs_done !== CNT_W'(exp_runs)) begin n_err++; $display("FAIL %s runs_done: got %0d expected %0d", name, runs_done, exp_runs); end
        n_vec++; if (last_latency !== CYC_W'(exp_last_lat)) begin n_err++; $display("FAIL %s last_latency: got %0d expected %0d", name, last_latency, exp_last_lat); end
        @(posedge ap_clk); #1;
        irq_clr = 1'b0;
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL %s irq_clear: got %b expected 0", name, irq); end
        repeat (2) @(posedge ap_clk); #1;
        n_vec++; if (sd_q.size() != 1) begin n_err++; $display("FAIL %s seq_done_pulses: got %0d expected 1", name, sd_q.size()); end
        n_vec++; if (start_q.size() != exp_runs) begin n_err++; $display("FAIL %s launches: got %0d expected %0d", name, start_q.size(), exp_runs); end
        for (int i = 0; i < exp_runs && i < start_q.size(); i++) begin
            n_vec++; if (start_q[i] !== exp_s[i]) begin n_err++; $display("FAIL %s launch%0d_cycle: got %0d expected %0d", name, i, start_q[i] - t0, exp_s[i] - t0); end
        end
        n_vec++; if (hi_cnt != exp_runs * (r + 1)) begin n_err++; $display("FAIL %s start_high_cycles: got %0d expected %0d", name, hi_cnt, exp_runs * (r + 1)); end
    endtask

    task automatic test_reset;
        #1 ap_rst_n = 1'b0;
        #1;
        n_vec++; if ({core_ap_start, busy, seq_done, runs_done, last_latency, irq} !== '0) begin n_err++; $display("FAIL reset_outputs: got %h expected 0", {core_ap_start, busy, seq_done, runs_done, last_latency, irq}); end
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk) ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;
        n_vec++; if ({core_ap_start, busy, seq_done, irq} !== 4'b0) begin n_err++; $display("FAIL reset_release_idle: got %b expected 0000", {core_ap_start, busy, seq_done, irq}); end
    endtask

    task automatic test_start_gating;
        @(posedge ap_clk); #1;
        start_q.delete(); force_busy = 1'b1;
        @(posedge ap_clk); #1;
        cfg_num_runs = CNT_W'(2); cfg_start = 1'b1;
        @(posedge ap_clk); #1;
        cfg_start = 1'b0; force_busy = 1'b0;
        repeat (3) @(posedge ap_clk); #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL gating_busy: got %b expected 0", busy); end
        n_vec++; if (start_q.size() != 0) begin n_err++; $display("FAIL gating_launch: got %0d launches expected 0", start_q.size()); end
    endtask

    task automatic test_reset_mid_run;
        int t0;
        rdy_off = 1; done_off = 8;
        @(posedge ap_clk); #1;
        t0 = cyc;
        cfg_num_runs = CNT_W'(3); cfg_gap = '0; cfg_start = 1'b1;
        @(posedge ap_clk); #1;
        cfg_start = 1'b0;
        repeat (3) @(posedge ap_clk);
        #3;
        n_vec++; if ({busy, core_ap_start} !== 2'b10) begin n_err++; $display("FAIL midrun_state: got busy,start=%b expected 10", {busy, core_ap_start}); end
        ap_rst_n = 1'b0;
        #1;
        n_vec++; if ({core_ap_start, busy, seq_done, runs_done, last_latency, irq} !== '0) begin n_err++; $display("FAIL midrun_reset_outputs: got %h expected 0", {core_ap_start, busy, seq_done, runs_done, last_latency, irq}); end
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk) ap_rst_n = 1'b1;
        exp_last_lat = 0;
        run_batch("post_reset", 2, 1, 1, 4, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random;
        int n, g, r, d, amode, ak;
        bit clr_fin, spur;
        for (int it = 0; it < 12; it++) begin
            n = $urandom_range(0, 4); g = $urandom_range(0, 5);
            r = $urandom_range(0, 3); d = r + $urandom_range(0, 6);
            amode = 0; ak = 0;
            if (n >= 2) begin
                case ($urandom_range(0, 2))
                    1: if (d >= r + 2) begin amode = 1; ak = $urandom_range(1, n - 1); end
                    2: if (g >= 2)     begin amode = 2; ak = $urandom_range(1, n - 1); end
                    default: ;
                endcase
            end
            clr_fin = ($urandom_range(0, 1) == 1);
            spur    = (n > 0) && ($urandom_range(0, 1) == 1);
            run_batch($sformatf("rand%0d", it), n, g, r, d, amode, ak, clr_fin, spur);
        end
    endtask

    initial begin
        test_reset();
        run_batch("t1_three_runs",    3, 0, 2, 9, 0, 0, 1'b0, 1'b0);
        run_batch("t2_zero_runs",     0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        run_batch("t3_abort",         5, 0, 2, 9, 1, 2, 1'b0, 1'b0);
        run_batch("t3b_slow_ready",   5, 0, 6, 9, 1, 2, 1'b0, 1'b0);
        run_batch("t4_gap",           2, 4, 0, 0, 0, 0, 1'b0, 1'b0);
        run_batch("t4b_abort_in_gap", 3, 3, 1, 2, 2, 1, 1'b0, 1'b0);
        run_batch("t5_irq_busy",      2, 1, 1, 3, 0, 0, 1'b1, 1'b1);
        test_start_gating();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
